// File: rtl/spdif_subframe_decoder_pkg.sv
// spdif_pkg: shared types and constants for the S/PDIF subframe receive path.
//   run_class_t : classification of one transition-to-transition run
//   preamble_t  : which of the three preambles started the subframe
//   fsm_t       : decoder state
//   SLOT_*      : slot numbers inside a 32-slot subframe
package spdif_pkg;

    typedef enum logic [1:0] {
        SHORT = 2'd0,
        LONG  = 2'd1,
        PRE   = 2'd2,
        BAD   = 2'd3
    } run_class_t;

    typedef enum logic [1:0] {
        PRE_B = 2'd0,
        PRE_M = 2'd1,
        PRE_W = 2'd2
    } preamble_t;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PRE_COL = 2'd1,
        DATA    = 2'd2,
        EXPECT  = 2'd3
    } fsm_t;

    localparam int SLOT_AUDIO_LO = 4;
    localparam int SLOT_V        = 28;
    localparam int SLOT_U        = 29;
    localparam int SLOT_C        = 30;
    localparam int SLOT_P        = 31;

    // Run length in unit intervals; BAD maps to 0.
    function automatic logic [1:0] run_ui(run_class_t rc);
        case (rc)
            SHORT:   return 2'd1;
            LONG:    return 2'd2;
            PRE:     return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Every preamble is 3,x,y,z UI. The second run of x,y,z is always 1 UI,
    // so x alone identifies the preamble and fixes what z must be.
    function automatic logic [1:0] third_ui(logic [1:0] first);
        case (first)
            2'd1:    return 2'd3;   // B: 3,1,1,3
            2'd2:    return 2'd2;   // W: 3,2,1,2
            default: return 2'd1;   // M: 3,3,1,1
        endcase
    endfunction

    function automatic preamble_t pre_of(logic [1:0] first);
        case (first)
            2'd1:    return PRE_B;
            2'd2:    return PRE_W;
            default: return PRE_M;
        endcase
    endfunction

endpackage

// File: rtl/spdif_subframe_decoder_run_classifier.sv
// spdif_run_classifier: synchronises the biphase-mark line, detects
// transitions and classifies each completed run by its clock count.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : raw line, asynchronous to clk
//   edge_stb   : a transition was seen this cycle
//   run_class  : class of the run that this transition ended (valid with edge_stb)
module spdif_run_classifier
    import spdif_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 6,
    parameter int RUN_MIN     = 5,
    parameter int T1_MAX      = 14,
    parameter int T2_MAX      = 24,
    parameter int T3_MAX      = 34
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    output logic       edge_stb,
    output run_class_t run_class
);

    localparam logic [CNT_W-1:0] RUN_MIN_C = CNT_W'(RUN_MIN);
    localparam logic [CNT_W-1:0] T1_C      = CNT_W'(T1_MAX);
    localparam logic [CNT_W-1:0] T2_C      = CNT_W'(T2_MAX);
    localparam logic [CNT_W-1:0] T3_C      = CNT_W'(T3_MAX);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic [CNT_W-1:0]       cnt;

    assign edge_stb = sync[SYNC_STAGES-1] ^ prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
            cnt  <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
            if (edge_stb)
                cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            else if (cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the length of the run that the current edge terminates.
    // A saturated count means the true length is unknown, so it is BAD even
    // when the thresholds would otherwise accept it.
    always_comb begin
        run_class = BAD;
        if (cnt == '1 || cnt < RUN_MIN_C)
            run_class = BAD;
        else if (cnt <= T1_C)
            run_class = SHORT;
        else if (cnt <= T2_C)
            run_class = LONG;
        else if (cnt <= T3_C)
            run_class = PRE;
    end

endmodule

// File: rtl/spdif_subframe_decoder.sv
// spdif_subframe_decoder: S/PDIF receive front end. Decodes preamble and
// 28 data slots from the biphase-mark line into one parallel subframe.
//   clk, rst_n      : clock, asynchronous active-low reset
//   din             : raw line input
//   sample          : audio slots 4..27 (LSB first on the line), top AUDIO_W bits
//   channel         : 0 = B/M preamble, 1 = W preamble
//   block_start     : subframe began with B
//   v_bit/u_bit/c_bit : slots 28/29/30
//   parity_ok       : even parity over slots 4..31
//   out_valid       : one-cycle strobe, outputs above held until the next one
//   locked          : LOCK_FRAMES good subframes seen since the last error
//   err             : one-cycle strobe on any line-coding error
//
// state   | meaning
// HUNT    | no framing; waiting for a 3-UI run
// PRE_COL | 3-UI run seen, collecting the remaining three preamble runs
// DATA    | decoding slots 4..31
// EXPECT  | subframe complete, next run must open a preamble
module spdif_subframe_decoder
    import spdif_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 6,
    parameter int RUN_MIN     = 5,
    parameter int T1_MAX      = 14,
    parameter int T2_MAX      = 24,
    parameter int T3_MAX      = 34,
    parameter int AUDIO_W     = 24,
    parameter int LOCK_FRAMES = 4
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din,
    output logic [AUDIO_W-1:0] sample,
    output logic               channel,
    output logic               block_start,
    output logic               v_bit,
    output logic               u_bit,
    output logic               c_bit,
    output logic               parity_ok,
    output logic               out_valid,
    output logic               locked,
    output logic               err
);

    localparam int             LCW      = $clog2(LOCK_FRAMES + 1);
    localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_FRAMES);
    localparam int             AUD_HI   = SLOT_V - SLOT_AUDIO_LO - 1;

    logic       edge_stb;
    run_class_t rc;
    logic [1:0] ui;

    spdif_run_classifier #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W),
        .RUN_MIN     (RUN_MIN),
        .T1_MAX      (T1_MAX),
        .T2_MAX      (T2_MAX),
        .T3_MAX      (T3_MAX)
    ) u_classifier (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .edge_stb  (edge_stb),
        .run_class (rc)
    );

    assign ui = run_ui(rc);

    fsm_t           state, state_n;
    logic [1:0]     pc_idx, pc_idx_n;
    logic [1:0]     pc_first, pc_first_n;
    preamble_t      pre_type, pre_n;
    logic           half, half_n;       // first 1-UI half of a '1' bit seen
    logic [4:0]     slot, slot_n;
    logic [27:0]    bits, bits_n;       // bits[k] = slot k+4
    logic           bit_done, bit_val;
    logic           frame_done, err_n;
    logic           par_n;
    logic [LCW-1:0] lock_cnt, lock_cnt_n;
    logic           locked_n;

    always_comb begin
        state_n    = state;
        pc_idx_n   = pc_idx;
        pc_first_n = pc_first;
        pre_n      = pre_type;
        half_n     = half;
        slot_n     = slot;
        bits_n     = bits;
        bit_done   = 1'b0;
        bit_val    = 1'b0;
        frame_done = 1'b0;
        err_n      = 1'b0;
        if (edge_stb) begin
            if (rc == BAD) begin
                err_n   = 1'b1;
                state_n = HUNT;
            end else begin
                case (state)
                    HUNT: begin
                        if (rc == PRE) begin
                            state_n  = PRE_COL;
                            pc_idx_n = 2'd0;
                        end
                    end
                    PRE_COL: begin
                        // A PRE that cannot belong to the current preamble is
                        // taken as the opening run of a new one.
                        case (pc_idx)
                            2'd0: begin
                                pc_first_n = ui;
                                pc_idx_n   = 2'd1;
                            end
                            2'd1: begin
                                if (rc == SHORT) begin
                                    pc_idx_n = 2'd2;
                                end else if (rc == PRE) begin
                                    pc_idx_n = 2'd0;
                                end else begin
                                    err_n   = 1'b1;
                                    state_n = HUNT;
                                end
                            end
                            default: begin
                                if (ui == third_ui(pc_first)) begin
                                    state_n = DATA;
                                    pre_n   = pre_of(pc_first);
                                    slot_n  = 5'(SLOT_AUDIO_LO);
                                    half_n  = 1'b0;
                                end else if (rc == PRE) begin
                                    pc_idx_n = 2'd0;
                                end else begin
                                    err_n   = 1'b1;
                                    state_n = HUNT;
                                end
                            end
                        endcase
                    end
                    DATA: begin
                        if (half) begin
                            if (rc == SHORT) begin
                                bit_done = 1'b1;
                                bit_val  = 1'b1;
                            end else begin
                                err_n   = 1'b1;
                                state_n = HUNT;
                            end
                        end else begin
                            case (rc)
                                SHORT: half_n = 1'b1;
                                LONG: begin
                                    bit_done = 1'b1;
                                    bit_val  = 1'b0;
                                end
                                default: begin
                                    state_n  = PRE_COL;
                                    pc_idx_n = 2'd0;
                                end
                            endcase
                        end
                    end
                    default: begin
                        if (rc == PRE) begin
                            state_n  = PRE_COL;
                            pc_idx_n = 2'd0;
                        end else begin
                            err_n   = 1'b1;
                            state_n = HUNT;
                        end
                    end
                endcase
            end
            if (bit_done) begin
                half_n = 1'b0;
                bits_n[slot - 5'(SLOT_AUDIO_LO)] = bit_val;
                if (slot == 5'(SLOT_P)) begin
                    state_n    = EXPECT;
                    frame_done = 1'b1;
                end else begin
                    slot_n = slot + 5'd1;
                end
            end
        end
    end

    assign par_n = ~^bits_n;

    // A parity failure only restarts the good-frame count; lock itself is
    // dropped by line-coding errors alone.
    always_comb begin
        lock_cnt_n = lock_cnt;
        locked_n   = locked;
        if (err_n) begin
            lock_cnt_n = '0;
            locked_n   = 1'b0;
        end else if (frame_done) begin
            if (par_n) begin
                if (lock_cnt != LOCK_MAX)
                    lock_cnt_n = lock_cnt + 1'b1;
            end else begin
                lock_cnt_n = '0;
            end
            if (lock_cnt_n == LOCK_MAX)
                locked_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            pc_idx      <= '0;
            pc_first    <= '0;
            pre_type    <= PRE_B;
            half        <= 1'b0;
            slot        <= '0;
            bits        <= '0;
            lock_cnt    <= '0;
            locked      <= 1'b0;
            err         <= 1'b0;
            out_valid   <= 1'b0;
            sample      <= '0;
            channel     <= 1'b0;
            block_start <= 1'b0;
            v_bit       <= 1'b0;
            u_bit       <= 1'b0;
            c_bit       <= 1'b0;
            parity_ok   <= 1'b0;
        end else begin
            state     <= state_n;
            pc_idx    <= pc_idx_n;
            pc_first  <= pc_first_n;
            pre_type  <= pre_n;
            half      <= half_n;
            slot      <= slot_n;
            bits      <= bits_n;
            lock_cnt  <= lock_cnt_n;
            locked    <= locked_n;
            err       <= err_n;
            out_valid <= frame_done;
            if (frame_done) begin
                sample      <= bits_n[AUD_HI -: AUDIO_W];
                channel     <= (pre_type == PRE_W);
                block_start <= (pre_type == PRE_B);
                v_bit       <= bits_n[SLOT_V - SLOT_AUDIO_LO];
                u_bit       <= bits_n[SLOT_U - SLOT_AUDIO_LO];
                c_bit       <= bits_n[SLOT_C - SLOT_AUDIO_LO];
                parity_ok   <= par_n;
            end
        end
    end

endmodule

// File: tb/tb_spdif_subframe_decoder.sv
module tb_spdif_subframe_decoder;

    localparam int SYNC    = 2;
    localparam int LOCK_N  = 4;
    localparam int NO_RUNT = -1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din = 1'b0;

    logic [23:0] s24;
    logic ch, bs, vb, ub, cb, pok, ov, lk, er;
    logic [15:0] s16;
    logic ch16, bs16, vb16, ub16, cb16, pok16, ov16, lk16, er16;

    spdif_subframe_decoder #(.SYNC_STAGES(SYNC), .AUDIO_W(24), .LOCK_FRAMES(LOCK_N)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .sample(s24), .channel(ch), .block_start(bs),
        .v_bit(vb), .u_bit(ub), .c_bit(cb), .parity_ok(pok), .out_valid(ov), .locked(lk), .err(er));

    spdif_subframe_decoder #(.SYNC_STAGES(SYNC), .AUDIO_W(16), .LOCK_FRAMES(LOCK_N)) dut16 (
        .clk(clk), .rst_n(rst_n), .din(din), .sample(s16), .channel(ch16), .block_start(bs16),
        .v_bit(vb16), .u_bit(ub16), .c_bit(cb16), .parity_ok(pok16), .out_valid(ov16), .locked(lk16), .err(er16));

    always #8 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [23:0] s24;
        logic [15:0] s16;
        logic        ch, bs, v, u, c, pok, lk;
    } strobe_t;

    typedef struct {
        int          pre;       // 0 = B, 1 = M, 2 = W
        logic [23:0] audio;
        logic        v, u, c;
        bit          flip;      // corrupt the parity slot
        int          runt_slot; // NO_RUNT or slot receiving a 2-clk runt
        bit          rst_mid;   // pulse reset inside the data slots
    } frame_t;

    strobe_t sq[$];
    frame_t  fq[$];
    int      tcyc[$];
    int      err_cnt = 0;
    int      ov16_cnt = 0;
    int      errors = 0;
    int      checks = 0;
    bit      ui_alt = 1'b0;

    always @(negedge clk) begin : mon
        strobe_t s;
        s.cyc = cyc; s.s24 = s24; s.s16 = s16; s.ch = ch; s.bs = bs;
        s.v = vb; s.u = ub; s.c = cb; s.pok = pok; s.lk = lk;
        if (ov) sq.push_back(s);
        if (er) err_cnt++;
        if (ov16) ov16_cnt++;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, " s24"}, {8'h0, s24}, 0);
        chk({tag, " flags"}, {23'h0, ch, bs, vb, ub, cb, pok, ov, lk, er}, 0);
        chk({tag, " s16"}, {16'h0, s16}, 0);
        chk({tag, " flags16"}, {23'h0, ch16, bs16, vb16, ub16, cb16, pok16, ov16, lk16, er16}, 0);
    endtask

    task automatic run(int n_ui);
        int clocks;
        clocks = 0;
        for (int i = 0; i < n_ui; i++) begin
            clocks += ui_alt ? 10 : 9;
            ui_alt = ~ui_alt;
        end
        din = ~din;
        repeat (clocks) @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_frame(frame_t f);
        logic [27:0] w;
        logic        p;
        int          pr[4];
        p = (^{f.c, f.u, f.v, f.audio}) ^ f.flip;
        w = {p, f.c, f.u, f.v, f.audio};
        case (f.pre)
            0:       pr = '{3, 1, 1, 3};
            1:       pr = '{3, 3, 1, 1};
            default: pr = '{3, 2, 1, 2};
        endcase
        tcyc.push_back(cyc);
        for (int i = 0; i < 4; i++) run(pr[i]);
        for (int s = 4; s < 32; s++) begin
            if (s == f.runt_slot) begin
                din = ~din;
                repeat (2) @(negedge clk);
            end
            if (f.rst_mid && s == 16) reset_pulse();
            if (w[s-4]) begin run(1); run(1); end
            else run(2);
        end
    endtask

    task automatic add_frame(int pre, logic [23:0] audio, logic [2:0] vuc, bit flip, int runt_slot, bit rst_mid);
        frame_t f;
        f.pre = pre; f.audio = audio; f.v = vuc[2]; f.u = vuc[1]; f.c = vuc[0];
        f.flip = flip; f.runt_slot = runt_slot; f.rst_mid = rst_mid;
        fq.push_back(f);
    endtask

    // Sends the queued frames as one stream from an idle line, then compares
    // every strobe with a frame-level model of decode and lock behaviour.
    task automatic play(string tag);
        strobe_t eq[$];
        strobe_t e;
        int      good, e0, v0, eexp, n;
        bit      lk_m, any_rst;
        sq.delete(); tcyc.delete();
        e0 = err_cnt; v0 = ov16_cnt;
        foreach (fq[i]) send_frame(fq[i]);
        tcyc.push_back(cyc);
        din = ~din;
        repeat (100) @(negedge clk);

        good = 0; lk_m = 1'b0; eexp = 1; any_rst = 1'b0;  // idle line ends as a BAD run
        foreach (fq[i]) begin
            if (fq[i].runt_slot != NO_RUNT || fq[i].rst_mid) begin
                good = 0; lk_m = 1'b0;
                if (fq[i].rst_mid) any_rst = 1'b1; else eexp++;
            end else begin
                e.cyc = tcyc[i+1] + SYNC + 1;
                e.s24 = fq[i].audio;
                e.s16 = fq[i].audio[23:8];
                e.ch  = (fq[i].pre == 2);
                e.bs  = (fq[i].pre == 0);
                e.v = fq[i].v; e.u = fq[i].u; e.c = fq[i].c;
                e.pok = !fq[i].flip;
                if (e.pok) begin
                    if (good < LOCK_N) good++;
                    if (good == LOCK_N) lk_m = 1'b1;
                end else good = 0;
                e.lk = lk_m;
                eq.push_back(e);
            end
        end
        chk({tag, " strobe_count"}, sq.size(), eq.size());
        chk({tag, " strobe16_count"}, ov16_cnt - v0, eq.size());
        if (!any_rst) chk({tag, " err_count"}, err_cnt - e0, eexp);
        n = (sq.size() < eq.size()) ? sq.size() : eq.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d] strobe_cycle", tag, i), sq[i].cyc, eq[i].cyc);
            chk($sformatf("%s[%0d] sample", tag, i), {8'h0, sq[i].s24}, {8'h0, eq[i].s24});
            chk($sformatf("%s[%0d] sample16", tag, i), {16'h0, sq[i].s16}, {16'h0, eq[i].s16});
            chk($sformatf("%s[%0d] ch_bs_vuc_pok", tag, i),
                {26'h0, sq[i].ch, sq[i].bs, sq[i].v, sq[i].u, sq[i].c, sq[i].pok},
                {26'h0, eq[i].ch, eq[i].bs, eq[i].v, eq[i].u, eq[i].c, eq[i].pok});
            chk($sformatf("%s[%0d] locked", tag, i), sq[i].lk, eq[i].lk);
        end
        fq.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        din = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            din = ~din;
            repeat (4) @(negedge clk);
            chk_zero($sformatf("rst_hold%0d", i));
        end
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        sq.delete();
        for (int i = 0; i < 40; i++) run($urandom_range(1, 2));
        repeat (100) @(negedge clk);
        chk("no_preamble strobe_count", sq.size(), 0);

        add_frame(0, 24'hA5A5A5, 3'b010, 1'b0, NO_RUNT, 1'b0);
        play("b_frame");

        for (int i = 0; i < 8; i++)
            add_frame((i % 2) ? 2 : 1, 24'(i + 1), 3'($urandom_range(0, 7)), i == 4, NO_RUNT, 1'b0);
        play("mw_lock");

        for (int i = 0; i < 7; i++)
            add_frame($urandom_range(0, 2), 24'($urandom), 3'($urandom_range(0, 7)), 1'b0,
                      (i == 4) ? 12 : NO_RUNT, 1'b0);
        play("runt");

        add_frame(0, 24'h123456, 3'b000, 1'b0, NO_RUNT, 1'b0);
        add_frame(1, 24'($urandom), 3'b101, 1'b0, NO_RUNT, 1'b1);
        add_frame(2, 24'($urandom), 3'b011, 1'b0, NO_RUNT, 1'b0);
        play("rst_mid");

        for (int i = 0; i < 10; i++)
            add_frame($urandom_range(0, 2), 24'($urandom), 3'($urandom_range(0, 7)),
                      $urandom_range(0, 3) == 0, NO_RUNT, 1'b0);
        play("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
